dmem_arbiter: RTL

Shares the single data-memory port between two requesters: the CPU load/store path (port 0) and a debug/loader master (port 1). It selects one request per cycle and drives the memory port. It then routes the one-cycle-latency read data back to whichever requester issued the read. It sits between the pipeline's memory stage, the debug interface and dmem, and produces a CPU stall when the CPU loses arbitration.

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug and data-memory signals around dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding
// environment (pipeline, debug port and memory model).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [3:0]        dbg_be;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;

  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata,
    output stall_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata,
    input  stall_cnt
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and the debug
// master. Grants are combinational; read data (one-cycle latency) is routed
// back using a registered owner tag.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | CPU priority, debug force-granted after MAX_WAIT denials
// LOCKED | debug owns the port for a burst; CPU is held off
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  // Width must hold MAX_WAIT itself; MAX_WAIT=0 still needs one bit.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_n;
  logic [WAIT_W-1:0] wait_q;
  logic              cpu_gnt, dbg_gnt;
  logic              cpu_stall;
  logic              rd_vld_q, rd_own_q;
  logic [CNT_W-1:0]  stall_q;
  logic [ADDR_W-1:0] addr_mux;

  // Arbitration and next-state; grants are forced low during reset.
  always_comb begin
    state_n = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req && bus.dbg_req) begin
          if (wait_q < WAIT_MAX) cpu_gnt = 1'b1;
          else                   dbg_gnt = 1'b1;
        end else begin
          cpu_gnt = bus.cpu_req;
          dbg_gnt = bus.dbg_req;
        end
        if (dbg_gnt && bus.dbg_lock) state_n = LOCKED;
      end
      LOCKED: begin
        dbg_gnt = bus.dbg_req;
        if (!bus.dbg_lock) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end
  end

  // Memory port mux: the debug fields win only when debug holds the grant.
  always_comb begin
    bus.mem_en    = cpu_gnt | dbg_gnt;
    bus.mem_we    = dbg_gnt ? bus.dbg_we : (cpu_gnt & bus.cpu_we);
    addr_mux      = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
    bus.mem_wdata = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;
    bus.mem_be    = dbg_gnt ? bus.dbg_be : bus.cpu_be;
  end

  assign bus.mem_addr  = addr_mux;
  assign cpu_stall     = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.cpu_stall = cpu_stall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Starvation counter: counts consecutive denied debug cycles, saturating.
  always_ff @(posedge clk) begin
    if (rst)                             wait_q <= '0;
    else if (!bus.dbg_req || dbg_gnt)    wait_q <= '0;
    else if (wait_q < WAIT_MAX)          wait_q <= wait_q + 1'b1;
  end

  // Read-return tag: remembers whether a read was accepted and for whom.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      rd_vld_q <= (cpu_gnt & bus.cpu_req & ~bus.cpu_we) |
                  (dbg_gnt & bus.dbg_req & ~bus.dbg_we);
      rd_own_q <= dbg_gnt;
    end
  end

  // Saturating CPU stall statistics counter.
  always_ff @(posedge clk) begin
    if (rst)                                stall_q <= '0;
    else if (cpu_stall && (stall_q != '1))  stall_q <= stall_q + 1'b1;
  end

  // Read data is steered to the tagged owner and zeroed otherwise.
  always_comb begin
    bus.cpu_rvalid = rd_vld_q & ~rd_own_q;
    bus.dbg_rvalid = rd_vld_q &  rd_own_q;
    bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : 32'h0;
    bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'h0;
  end

  assign bus.stall_cnt = stall_q;

endmodule
